// File: rtl/dma_pkg.sv
// Shared encodings for the single-channel DMA controller.
// Holds the FSM state type, the register-select values and the CTRL/STATUS bit positions.
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSREQ,
        S_ACK,
        S_XFER,
        S_RELEASE
    } state_t;

    localparam logic [1:0] SEL_BASE   = 2'd0;
    localparam logic [1:0] SEL_COUNT  = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_CLR = 1;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

endpackage

// File: rtl/dma_cfg_regs.sv
// CPU-visible BASE/COUNT/CTRL/STATUS registers and read mux for dma_chan_ctrl.
// Config writes land only while the channel is idle; irq-clear is honoured at any time.
module dma_cfg_regs
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              idle,
    input  logic              start,
    input  logic              set_err,
    input  logic              set_done,
    output logic [ADDR_W-1:0] base,
    output logic [CNT_W-1:0]  count,
    output logic              enable,
    output logic              reload,
    output logic              done_irq
);

    logic busy;
    logic done;
    logic err;
    logic cfg_wr;
    logic irq_clr;
    logic unused_wdata;

    assign cfg_wr       = cfg_we && idle;
    assign irq_clr      = cfg_we && (cfg_sel == SEL_CTRL) && cfg_wdata[CTRL_CLR];
    assign unused_wdata = ^cfg_wdata[DATA_W-1:ADDR_W];
    assign done_irq     = done | err;

    // reload marks a pending config change: the next start re-seeds the address
    // from BASE and clears done/err; a back-to-back restart continues where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base   <= '0;
            count  <= '0;
            enable <= 1'b0;
            reload <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (start) begin
                busy   <= 1'b1;
                reload <= 1'b0;
                if (reload) begin
                    done <= 1'b0;
                    err  <= 1'b0;
                end
            end
            if (cfg_wr) begin
                case (cfg_sel)
                    SEL_BASE: begin
                        base   <= cfg_wdata[ADDR_W-1:0];
                        reload <= 1'b1;
                    end
                    SEL_COUNT: begin
                        count  <= cfg_wdata[CNT_W-1:0];
                        reload <= 1'b1;
                    end
                    SEL_CTRL: begin
                        enable <= cfg_wdata[CTRL_EN];
                        reload <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (irq_clr) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (set_done) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_sel)
            SEL_BASE:  cfg_rdata[ADDR_W-1:0] = base;
            SEL_COUNT: cfg_rdata[CNT_W-1:0]  = count;
            SEL_CTRL:  cfg_rdata[CTRL_EN]    = enable;
            default: begin
                cfg_rdata[STAT_BUSY] = busy;
                cfg_rdata[STAT_DONE] = done;
                cfg_rdata[STAT_ERR]  = err;
            end
        endcase
    end

endmodule

// File: rtl/dma_chan_ctrl.sv
// Single-channel DMA: on device request, takes the bus via HOLD/HLDA, streams the
// device buffer into data memory at incrementing addresses, then releases and interrupts.
module dma_chan_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              dreq,
    output logic              dack,
    output logic              dev_iowrite,
    input  logic [DATA_W-1:0] dev_data,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done_irq
);

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  remaining;
    logic              enable;
    logic              reload;
    logic              idle;
    logic              start;
    logic              abort;
    logic              wr;
    logic              set_done;

    assign idle     = (state == S_IDLE);
    assign start    = idle && enable && dreq && (count != '0);
    // Losing the grant outranks everything else in ACK/XFER, including an empty device.
    assign abort    = ((state == S_ACK) || (state == S_XFER)) && !hold_ack;
    assign wr       = (state == S_XFER) && hold_ack && dreq;
    assign set_done = (state == S_RELEASE);

    dma_cfg_regs #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cfg_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .idle      (idle),
        .start     (start),
        .set_err   (abort),
        .set_done  (set_done),
        .base      (base),
        .count     (count),
        .enable    (enable),
        .reload    (reload),
        .done_irq  (done_irq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_BUSREQ;
            S_BUSREQ:  if (hold_ack) state_nxt = S_ACK;
            S_ACK:     state_nxt = abort ? S_RELEASE : S_XFER;
            S_XFER: begin
                if (!hold_ack || !dreq || (remaining == CNT_W'(1))) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hold_req = 1'b0;
        dack     = 1'b0;
        case (state)
            S_BUSREQ: hold_req = 1'b1;
            S_ACK, S_XFER: begin
                hold_req = 1'b1;
                dack     = 1'b1;
            end
            default: ;
        endcase
        dev_iowrite = !dack;
    end

    // Memory port is registered as a unit so we/addr/wdata line up in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr;
            if (start) begin
                remaining <= count;
                if (reload) begin
                    addr <= base;
                end
            end
            if (wr) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                mem_addr  <= addr;
                mem_wdata <= dev_data;
            end
        end
    end

endmodule

// File: doc/dma_chan_ctrl.md
Name: dma_chan_ctrl

Overview:
Single-channel DMA controller that sits directly downstream of IO device 1. It watches the device's GPIO1 interrupt line as a DMA request, acquires the system bus from the CPU with a HOLD/HLDA handshake, and drives Ack1 with IOWrite1=0 so the device streams its buffer. It writes each received word into data memory at an incrementing address, then releases the bus and raises a done interrupt to the CPU. The CPU programs the base address and word count through a small register port.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 13, data-memory word address width (8192 words)
CNT_W, 5, word-count width (max 31 words, equal to device buffer depth)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  CPU register write strobe
cfg_sel  in  2  register select: 0=BASE, 1=COUNT, 2=CTRL(bit0 enable, bit1 irq clear)
cfg_wdata  in  DATA_W  register write data
cfg_rdata  out  DATA_W  read mux of cfg_sel; 3=STATUS{err,done,busy}
dreq  in  1  DMA request, connected to device GPIO1
dack  out  1  to device Ack1
dev_iowrite  out  1  to device IOWrite1; 0 while dack is high, else 1
dev_data  in  DATA_W  device data bus
hold_req  out  1  bus request to CPU
hold_ack  in  1  bus grant from CPU
mem_we  out  1  data-memory write enable
mem_addr  out  ADDR_W  data-memory word address
mem_wdata  out  DATA_W  data-memory write data
done_irq  out  1  level interrupt to CPU

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0 except dev_iowrite=1. BASE, COUNT and CTRL reset to 0. done, err and busy clear. Reset during a transfer abandons it with no further memory writes.
- Config: register writes take effect at the next rising edge, only in IDLE. Writes in other states are ignored, except the CTRL irq-clear bit, which always clears done/err and therefore done_irq.
- FSM states:
  - IDLE: if enable && dreq && COUNT!=0, go to BUSREQ. Load addr=BASE and remaining=COUNT. Clear done/err. Set busy.
  - BUSREQ: hold_req=1. Wait for hold_ack=1, then go to ACK.
  - ACK: dack=1, dev_iowrite=0 for one latency cycle (device drives the word at negedge), then go to XFER.
  - XFER: dack=1. Each cycle, mem_we=1, mem_wdata=dev_data, mem_addr=addr. Then addr+1 and remaining-1. Go to RELEASE when remaining reaches 1 on this write, or when dreq=0 at sample time (device empty; no write that cycle).
  - RELEASE: dack=0, hold_req=0, dev_iowrite=1. Set done and clear busy. Go to IDLE.
- Latency: first memory write is 2 cycles after hold_ack is sampled high. Then 1 word per cycle. N words take N+3 cycles from grant to IDLE.
- Outputs are registered from state, except mem_wdata, which is a registered copy of dev_data, so mem_we/addr/wdata are coherent in the same cycle.
- Address arithmetic: mem_addr wraps modulo 2^ADDR_W (8191+1 -> 0). No error is flagged.
- COUNT uses the low CNT_W bits of cfg_wdata. COUNT=0 means the channel never starts, even with dreq high.
- hold_ack dropping in ACK or XFER: abort in the same cycle (no mem_we), set err, then RELEASE.
- dreq and hold_ack may change on the same edge; a hold_ack drop takes priority (err).
- done_irq = done | err, held until CPU irq-clear. If dreq is still high after RELEASE and enable=1, a new transfer starts from the updated addr (BASE is not reloaded until next config write). done stays set.

Decomposition:
- Package dma_pkg: state enum (IDLE, BUSREQ, ACK, XFER, RELEASE), cfg_sel encodings, STATUS bit positions.
- Sub-module dma_cfg_regs holds BASE/COUNT/CTRL/STATUS and the read mux. The FSM/datapath stays in dma_chan_ctrl.

Test Plan:
- BASE=100, COUNT=4, enable, dreq=1, grant 2 cycles later, device words A0..A3 -> mem writes addr 100..103 = A0..A3 on consecutive cycles; dack high 5 cycles; done_irq=1; STATUS=3'b010.
- COUNT=0, dreq=1 -> hold_req stays 0 for 20 cycles; no mem_we.
- BASE=8190, COUNT=3 -> writes at 8190, 8191, 0.
- COUNT=8, dreq drops after 3 words -> 3 writes only; done=1, err=0; final addr=BASE+3.
- hold_ack deasserted after 2nd word -> exactly 2 writes; err=1; hold_req and dack drop within 1 cycle; irq-clear write -> done_irq=0.
- rst_n low mid-XFER -> dack, hold_req, mem_we are 0 immediately (asynchronously); after release, registers read 0 and no transfer occurs.
